emif_async_slave: RTL and testbench

EMIF_ASYNC_SLAVE -- requirements
Module: emif_async_slave

---
 rtl/emif_async_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_emif_async_slave.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_async_slave.sv
// emif_async_slave: EMIF asynchronous-memory slave exposing NUM_CS banks of DEPTH register words.
// Latency: strobes cross a 2-flop synchroniser; commit + wr_stb 2 cycles after synced nWE rise; read data 2 cycles after synced nOE fall.
// Backpressure: none toward the core; with EMIF_SLAVE_WAIT_EN, nWAIT holds the EMIF master off for WAIT_CYC cycles per access.
//
// Ports: inclk0/rst (async active-high) | EMIF_nCS/nWE/nOE strobes (synchronised) | EMIF_nDQM, EMIF_A, EMIF_D
//        sampled at synced strobe edges | EMIF_BA ignored | EMIF_nWAIT wait request | wr_stb/wr_cs/wr_addr/wr_data
//        committed-write notification | err_cnt saturating protocol-error count.
// Macro EMIF_SLAVE_WAIT_EN: when defined, generates the nWAIT counter; otherwise EMIF_nWAIT is tied high.
module emif_async_slave #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 22,
  parameter int NUM_CS   = 2,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 3,
  localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                inclk0,
  input  logic                rst,
  input  logic [NUM_CS-1:0]   EMIF_nCS,
  input  logic                EMIF_nWE,
  input  logic                EMIF_nOE,
  input  logic [DATA_W/8-1:0] EMIF_nDQM,
  input  logic [ADDR_W-1:0]   EMIF_A,
  input  logic [1:0]          EMIF_BA,
  inout  wire  [DATA_W-1:0]   EMIF_D,
  output logic                EMIF_nWAIT,
  output logic                wr_stb,
  output logic [CS_W-1:0]     wr_cs,
  output logic [IDX_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [7:0]          err_cnt
);

  localparam int NB      = DATA_W / 8;
  localparam int ADDR_SH = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WR, RD, WAITX, DONE} state_t;
  state_t state;

  logic [NUM_CS-1:0] csMeta, csSync;
  logic              weMeta, weSync, weSyncD;
  logic              oeMeta, oeSync, oeSyncD;
  logic [1:0]        primeCnt;
  logic              primed, weFall, oeFall;
  logic [CS_W-1:0]   csAct, csIdx;
  logic              csAny, addrOor, addrBad;
  logic [IDX_W-1:0]  addrIdx;
  logic [DATA_W-1:0] wrLat, merged, rdDat;
  logic [NB-1:0]     dqmLat;
  logic              drvEn;
  logic [DATA_W-1:0] regs [NUM_CS][DEPTH];
  logic              unusedBits;

  assign unusedBits = ^EMIF_BA;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // primeCnt reaches 3 once the whole edge-detect chain holds real pin samples,
  // so a strobe already low during reset never looks like a fresh falling edge.
  always_ff @(posedge inclk0 or posedge rst) begin
    if (rst) begin
      csMeta   <= '1;
      csSync   <= '1;
      weMeta   <= 1'b1;
      weSync   <= 1'b1;
      weSyncD  <= 1'b1;
      oeMeta   <= 1'b1;
      oeSync   <= 1'b1;
      oeSyncD  <= 1'b1;
      primeCnt <= '0;
    end else begin
      csMeta   <= EMIF_nCS;
      csSync   <= csMeta;
      weMeta   <= EMIF_nWE;
      weSync   <= weMeta;
      weSyncD  <= weSync;
      oeMeta   <= EMIF_nOE;
      oeSync   <= oeMeta;
      oeSyncD  <= oeSync;
      if (primeCnt != 2'd3) primeCnt <= primeCnt + 2'd1;
    end
  end

  assign primed  = (primeCnt == 2'd3);
  assign weFall  = primed && weSyncD && !weSync;
  assign oeFall  = primed && oeSyncD && !oeSync;
  assign addrOor = (EMIF_A >> ADDR_SH) != '0;

  // Lowest-index asserted chip select wins: later (lower) iterations overwrite.
  always_comb begin
    csAct = '0;
    csAny = 1'b0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!csSync[i]) begin
        csAct = CS_W'(i);
        csAny = 1'b1;
      end
    end
  end

  always_comb begin
    merged = regs[csIdx][addrIdx];
    for (int b = 0; b < NB; b++) begin
      if (!dqmLat[b]) merged[8*b +: 8] = wrLat[8*b +: 8];
    end
  end

  always_ff @(posedge inclk0 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      csIdx   <= '0;
      addrIdx <= '0;
      addrBad <= 1'b0;
      wrLat   <= '0;
      dqmLat  <= '0;
      rdDat   <= '0;
      drvEn   <= 1'b0;
      wr_stb  <= 1'b0;
      wr_cs   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      err_cnt <= '0;
      for (int c = 0; c < NUM_CS; c++)
        for (int a = 0; a < DEPTH; a++)
          regs[c][a] <= '0;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (csAny && (weFall || oeFall)) begin
            csIdx   <= csAct;
            addrIdx <= EMIF_A[IDX_W-1:0];
            addrBad <= addrOor;
            if (!weSync && !oeSync) begin
              err_cnt <= satInc(err_cnt);
              state   <= DONE;
            end else if (weFall) begin
              state <= WR;
            end else begin
              // Out-of-range reads are counted once here and return zeros.
              if (addrOor) err_cnt <= satInc(err_cnt);
              state <= RD;
            end
          end
        end
        WR: begin
          if (!oeSync) begin
            err_cnt <= satInc(err_cnt);
            state   <= DONE;
          end else if (weSync) begin
            wrLat  <= EMIF_D;
            dqmLat <= EMIF_nDQM;
            if (addrBad) begin
              err_cnt <= satInc(err_cnt);
              state   <= DONE;
            end else begin
              state <= WAITX;
            end
          end else if (csSync[csIdx]) begin
            err_cnt <= satInc(err_cnt);
            state   <= DONE;
          end
        end
        // Write commit: merge the byte-masked data and publish the result.
        WAITX: begin
          regs[csIdx][addrIdx] <= merged;
          wr_stb  <= 1'b1;
          wr_cs   <= csIdx;
          wr_addr <= addrIdx;
          wr_data <= merged;
          state   <= DONE;
        end
        RD: begin
          if (!weSync) begin
            err_cnt <= satInc(err_cnt);
            drvEn   <= 1'b0;
            state   <= DONE;
          end else if (oeSync || csSync[csIdx]) begin
            drvEn <= 1'b0;
            state <= DONE;
          end else begin
            drvEn <= 1'b1;
            rdDat <= addrBad ? '0 : regs[csIdx][addrIdx];
          end
        end
        DONE: begin
          if (weSync && oeSync && (&csSync)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign EMIF_D = (drvEn && state == RD) ? rdDat : 'z;

`ifdef EMIF_SLAVE_WAIT_EN
  logic [3:0] waitCnt;
  logic       enterAcc;

  // Same condition that moves IDLE into WR or RD (both-strobes-low excluded).
  assign enterAcc = (state == IDLE) && csAny && ((weFall && oeSync) || (oeFall && weSync));

  always_ff @(posedge inclk0 or posedge rst) begin
    if (rst) begin
      waitCnt    <= '0;
      EMIF_nWAIT <= 1'b1;
    end else if (enterAcc) begin
      waitCnt    <= 4'(WAIT_CYC);
      EMIF_nWAIT <= (WAIT_CYC == 0);
    end else if (waitCnt > 4'd1) begin
      waitCnt <= waitCnt - 4'd1;
    end else if (waitCnt == 4'd1) begin
      waitCnt    <= '0;
      EMIF_nWAIT <= 1'b1;
    end
  end
`else
  localparam int unusedWaitCyc = WAIT_CYC;
  assign EMIF_nWAIT = 1'b1;
`endif

endmodule

// File: tb/tb_emif_async_slave.sv
`timescale 1ns/1ps
module tb_emif_async_slave;
  localparam int DW  = 16;
  localparam int AW  = 22;
  localparam int NCS = 2;
  localparam int DEP = 16;
  localparam int WC  = 3;
`ifdef EMIF_SLAVE_WAIT_EN
  localparam int EXP_WAIT = WC;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [NCS-1:0] nCs;
  logic           nWe, nOe;
  logic [1:0]     nDqm, ba;
  logic [AW-1:0]  addr;
  wire  [DW-1:0]  emifD;
  logic           tbDrv;
  logic [DW-1:0]  tbDat;
  logic           nWait, wrStb, wrCs;
  logic [3:0]     wrAddr;
  logic [DW-1:0]  wrData;
  logic [7:0]     errCnt;

  assign emifD = tbDrv ? tbDat : 'z;
  for (genvar g = 0; g < DW; g++) begin : gPull
    pullup (emifD[g]);
  end

  emif_async_slave #(.DATA_W(DW), .ADDR_W(AW), .NUM_CS(NCS), .DEPTH(DEP), .WAIT_CYC(WC)) dut (
    .inclk0(clk), .rst(rst), .EMIF_nCS(nCs), .EMIF_nWE(nWe), .EMIF_nOE(nOe),
    .EMIF_nDQM(nDqm), .EMIF_A(addr), .EMIF_BA(ba), .EMIF_D(emifD),
    .EMIF_nWAIT(nWait), .wr_stb(wrStb), .wr_cs(wrCs), .wr_addr(wrAddr),
    .wr_data(wrData), .err_cnt(errCnt)
  );

  always #5 clk = ~clk;

  // Observation of the write-notification port and nWAIT, sampled on the falling edge.
  int         stbCnt = 0;
  int         waitLow = 0;
  logic       stbCsL;
  logic [3:0] stbAddrL;
  logic [15:0] stbDataL;
  always @(negedge clk) begin
    if (wrStb) begin
      stbCnt   = stbCnt + 1;
      stbCsL   = wrCs;
      stbAddrL = wrAddr;
      stbDataL = wrData;
    end
    if (!nWait) waitLow = waitLow + 1;
  end

  // Reference model: plain storage array plus an error tally clipped at 255.
  logic [15:0] model [NCS][DEP];
  int          expErr = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mergeW(input logic [15:0] old, input logic [15:0] d, input logic [1:0] dqm);
    logic [15:0] r;
    r = old;
    if (!dqm[0]) r[7:0]  = d[7:0];
    if (!dqm[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  function automatic int lowCs(input logic [1:0] m);
    return m[0] ? 1 : 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doWrite(input logic [1:0] csMask, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] dqm);
    int s0, w0, c;
    s0 = stbCnt;
    w0 = waitLow;
    c  = lowCs(csMask);
    @(negedge clk);
    nCs = csMask; addr = a; tbDat = d; tbDrv = 1'b1; nDqm = dqm;
    cyc(2); nWe = 1'b0;
    cyc(8); nWe = 1'b1;
    cyc(5); nCs = '1; tbDrv = 1'b0; nDqm = '1;
    cyc(4);
    if (a < DEP) begin
      model[c][a[3:0]] = mergeW(model[c][a[3:0]], d, dqm);
      chk("wr_stb_count", stbCnt - s0, 1);
      chk("wr_data", stbDataL, model[c][a[3:0]]);
      chk("wr_cs", stbCsL, c);
      chk("wr_addr", stbAddrL, a[3:0]);
    end else begin
      expErr = sat(expErr);
      chk("wr_oor_no_stb", stbCnt - s0, 0);
    end
    chk("wr_wait_cycles", waitLow - w0, EXP_WAIT);
    chk("wr_err_cnt", errCnt, expErr);
  endtask

  task automatic doRead(input int c, input logic [AW-1:0] a);
    int s0, w0;
    logic [15:0] rd, zv, ex;
    s0 = stbCnt;
    w0 = waitLow;
    @(negedge clk);
    nCs[c] = 1'b0; addr = a;
    cyc(2); nOe = 1'b0;
    cyc(8); rd = emifD;
    nOe = 1'b1;
    repeat (3) @(posedge clk);
    #1 zv = emifD;
    @(negedge clk); nCs = '1;
    cyc(4);
    if (a < DEP) ex = model[c][a[3:0]];
    else begin
      ex = 16'h0000;
      expErr = sat(expErr);
    end
    chk("rd_data", rd, ex);
    chk("rd_release_z", zv, 16'hFFFF);
    chk("rd_no_stb", stbCnt - s0, 0);
    chk("rd_wait_cycles", waitLow - w0, EXP_WAIT);
    chk("rd_err_cnt", errCnt, expErr);
  endtask

  // nWE and nOE asserted together; returns the bus value seen mid-event.
  task automatic bothLow(output logic [15:0] busMid);
    @(negedge clk);
    nCs[0] = 1'b0; addr = 22'd2;
    cyc(2); nWe = 1'b0; nOe = 1'b0;
    cyc(4); busMid = emifD;
    nWe = 1'b1; nOe = 1'b1;
    cyc(3); nCs = '1;
    cyc(4);
    expErr = sat(expErr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] busMid;
    int s0;
    for (int c = 0; c < NCS; c++)
      for (int a = 0; a < DEP; a++)
        model[c][a] = '0;
    rst = 1'b1; nCs = '1; nWe = 1'b1; nOe = 1'b1; nDqm = '1; addr = '0; ba = 2'b11;
    tbDrv = 1'b0; tbDat = '0;
    cyc(3);
    chk("rst_nwait", nWait, 1'b1);
    chk("rst_wr_stb", wrStb, 1'b0);
    chk("rst_wr_data", wrData, 16'h0);
    chk("rst_err", errCnt, 8'h0);
    chk("rst_bus_z", emifD, 16'hFFFF);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_wr_cs", wrCs, 1'b0);
    chk("post_rst_wr_addr", wrAddr, 4'h0);

    // Reset in the middle of a write; strobe stays low across the reset.
    s0 = stbCnt;
    @(negedge clk);
    nCs[0] = 1'b0; addr = 22'd5; tbDat = 16'h5A5A; tbDrv = 1'b1; nDqm = 2'b00;
    cyc(2); nWe = 1'b0;
    cyc(6); rst = 1'b1;
    cyc(2); rst = 1'b0;
    cyc(6); tbDrv = 1'b0;
    cyc(1);
    chk("rstmid_bus_z", emifD, 16'hFFFF);
    nWe = 1'b1;
    cyc(5); nCs = '1;
    cyc(4);
    chk("rstmid_no_stb", stbCnt - s0, 0);
    chk("rstmid_err", errCnt, 8'h0);
    doRead(0, 22'd5);
    doWrite(2'b10, 22'd5, 16'h00FF, 2'b00);
    doRead(0, 22'd5);

    // Byte-masked write sequence.
    doWrite(2'b10, 22'd3, 16'hA55A, 2'b00);
    doWrite(2'b10, 22'd3, 16'h1234, 2'b10);
    chk("mask_wr_data", stbDataL, 16'hA534);
    doRead(0, 22'd3);

    // Read back on the second chip select at the top address.
    doWrite(2'b01, 22'd15, 16'hBEEF, 2'b00);
    doRead(1, 22'd15);

    // Both chip selects low: the lower index is served.
    doWrite(2'b00, 22'd9, 16'hC0DE, 2'b00);
    doRead(0, 22'd9);
    doRead(1, 22'd9);

    // Out-of-range write then read.
    doWrite(2'b10, 22'h10, 16'h7777, 2'b00);
    doRead(0, 22'h10);
    chk("oor_err_two", errCnt, 8'd2);

    // Randomised traffic against the model.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01);
      doWrite(m, 22'($urandom_range(0, DEP - 1)), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 10; i++) begin
      doRead($urandom_range(0, NCS - 1), 22'($urandom_range(0, DEP - 1)));
    end

    // nWE and nOE low together.
    s0 = stbCnt;
    bothLow(busMid);
    chk("both_bus_z", busMid, 16'hFFFF);
    chk("both_no_stb", stbCnt - s0, 0);
    chk("both_err", errCnt, expErr);

    // Chip select released before the write strobe rises.
    s0 = stbCnt;
    @(negedge clk);
    nCs[1] = 1'b0; addr = 22'd7; tbDat = 16'hDEAD; tbDrv = 1'b1; nDqm = 2'b00;
    cyc(2); nWe = 1'b0;
    cyc(6); nCs = '1;
    cyc(5); nWe = 1'b1;
    cyc(5); tbDrv = 1'b0;
    cyc(4);
    expErr = sat(expErr);
    chk("csabort_no_stb", stbCnt - s0, 0);
    chk("csabort_err", errCnt, expErr);
    doRead(1, 22'd7);

    // Many protocol errors: the counter must pin at 255.
    s0 = stbCnt;
    for (int i = 0; i < 300; i++) bothLow(busMid);
    chk("sat_err_255", errCnt, 8'd255);
    chk("sat_model", expErr, errCnt);
    chk("sat_no_stb", stbCnt - s0, 0);
    doRead(1, 22'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
